mcu_band_reader: RTL and testbench

MCU_BAND_READER -- requirements
Module: mcu_band_reader

---
 rtl/mcu_band_reader_if.sv | 28 ++
 rtl/mcu_band_reader.sv | 100 ++++++++++
 tb/tb_mcu_band_reader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mcu_band_reader_if.sv
// mcu_band_reader_if: EBR read port plus downstream pixel stream handshake
interface mcu_band_reader_if #(
    parameter int num_ebr  = 5,
    parameter int ebr_size = 512
);
    localparam int bw = num_ebr > 1 ? $clog2(num_ebr) : 1;
    localparam int aw = $clog2(ebr_size);
    logic [bw-1:0] read_block_select;
    logic          read_buffer_select;
    logic [aw-1:0] read_addr;
    logic          rden;
    logic [7:0]    read_data;
    logic [7:0]    mcu_pixval;
    logic          mcu_valid;
    logic          mcu_ready;
    logic          mcu_first;
    logic          mcu_last;
    modport master (
        output read_block_select, read_buffer_select, read_addr, rden,
        output mcu_pixval, mcu_valid, mcu_first, mcu_last,
        input  read_data, mcu_ready
    );
    modport slave (
        input  read_block_select, read_buffer_select, read_addr, rden,
        input  mcu_pixval, mcu_valid, mcu_first, mcu_last,
        output read_data, mcu_ready
    );
endinterface

// File: rtl/mcu_band_reader.sv
// mcu_band_reader: streams a completed band out of the EBR bank as 8x8 MCUs through a 2-entry skid FIFO
module mcu_band_reader #(
    parameter int width_pix = 320,
    parameter int num_ebr   = 5,
    parameter int ebr_size  = 512
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              frontbuffer_select,
    mcu_band_reader_if.master bus,
    output logic              busy,
    output logic              overrun
);
    localparam int nm = width_pix / 8;
    localparam int bw = num_ebr > 1 ? $clog2(num_ebr) : 1;
    localparam int aw = $clog2(ebr_size);
    localparam int rw = aw - 6;
    localparam logic [bw-1:0] max_blk  = bw'(num_ebr - 1);
    localparam logic [bw-1:0] last_blk = bw'((nm - 1) % num_ebr);
    localparam logic [rw-1:0] last_row = rw'((nm - 1) / num_ebr);

    typedef enum logic [1:0] {s_idle, s_fetch, s_drain} state_t;
    state_t state, state_nx;

    logic          fb_q, band_done, inflight, tag_first, tag_last, pop, final_rd;
    logic [bw-1:0] blk;
    logic [rw-1:0] row;
    logic [5:0]    pix;
    logic [1:0]    cnt, wr_at;
    logic [9:0]    e0, e1, entry;

    assign band_done = frontbuffer_select != fb_q;
    assign pop       = bus.mcu_valid && bus.mcu_ready;
    assign wr_at     = cnt - {1'b0, pop};
    assign entry     = {tag_first, tag_last, bus.read_data};
    assign final_rd  = bus.rden && pix == 6'd63 && blk == last_blk && row == last_row;
    assign busy      = state != s_idle;
    // a read may only start if the FIFO can still absorb it once the in-flight read lands
    assign bus.rden  = state == s_fetch && int'(cnt) + int'(inflight) - int'(pop) < 2;
    assign bus.read_block_select = blk;
    assign bus.read_addr  = {row, pix};
    assign bus.mcu_valid  = cnt != 2'd0;
    assign bus.mcu_pixval = e0[7:0];
    assign bus.mcu_first  = bus.mcu_valid && e0[9];
    assign bus.mcu_last   = bus.mcu_valid && e0[8];

    // state register
    always_ff @(posedge clock or negedge nreset)
        if (!nreset) state <= s_idle;
        else         state <= state_nx;

    // next state: wait for a band, fetch it, then drain the FIFO
    always_comb begin
        state_nx = state;
        state_nx = state == s_idle  ? (band_done ? s_fetch : s_idle) :
                   state == s_fetch ? (final_rd ? s_drain : s_fetch) :
                   (cnt == 2'd0 && !inflight ? s_idle : s_drain);
    end

    // band detection, overrun flag and the MCU/pixel address counters
    always_ff @(posedge clock or negedge nreset)
        if (!nreset) begin
            fb_q                   <= 1'b0;
            bus.read_buffer_select <= 1'b0;
            overrun                <= 1'b0;
            inflight               <= 1'b0;
            tag_first              <= 1'b0;
            tag_last               <= 1'b0;
            blk                    <= '0;
            row                    <= '0;
            pix                    <= '0;
        end else begin
            fb_q      <= frontbuffer_select;
            inflight  <= bus.rden;
            tag_first <= pix == 6'd0;
            tag_last  <= pix == 6'd63;
            if (band_done && state == s_idle) bus.read_buffer_select <= fb_q;
            if (band_done && state != s_idle) overrun <= 1'b1;
            if (bus.rden) begin
                pix <= final_rd ? '0 : pix + 6'd1;
                if (pix == 6'd63) begin
                    blk <= (final_rd || blk == max_blk) ? '0 : blk + bw'(1);
                    row <= final_rd ? '0 : blk == max_blk ? row + rw'(1) : row;
                end
            end
        end

    // skid FIFO: e0 is the head, new data lands at the first free slot after any pop
    always_ff @(posedge clock or negedge nreset)
        if (!nreset) begin
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            cnt <= wr_at + {1'b0, inflight};
            if (pop && cnt == 2'd2)             e0 <= e1;
            else if (inflight && wr_at == 2'd0) e0 <= entry;
            if (inflight && wr_at == 2'd1)      e1 <= entry;
        end
endmodule

// File: tb/tb_mcu_band_reader.sv
// tb_mcu_band_reader: randomized backpressure bench against a raster-order reference model
module tb_mcu_band_reader;
    logic clock = 1'b0, nreset = 1'b0, fb = 1'b0, fb2 = 1'b0;
    logic busy, overrun, busy2, overrun2;
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int idx, ridx, exp_reads, bank_exp, duty;
    logic held;
    logic [9:0] hold_val, cur1;
    logic [26:0] outs1;

    mcu_band_reader_if #(.num_ebr(5), .ebr_size(512)) b1 ();
    mcu_band_reader_if #(.num_ebr(1), .ebr_size(512)) b2 ();

    mcu_band_reader dut (.clock(clock), .nreset(nreset), .frontbuffer_select(fb),
                         .bus(b1), .busy(busy), .overrun(overrun));
    mcu_band_reader #(.width_pix(16), .num_ebr(1), .ebr_size(512)) dut2 (
        .clock(clock), .nreset(nreset), .frontbuffer_select(fb2),
        .bus(b2), .busy(busy2), .overrun(overrun2));

    assign cur1  = {b1.mcu_first, b1.mcu_last, b1.mcu_pixval};
    assign outs1 = {busy, overrun, b1.rden, b1.mcu_valid, b1.mcu_first, b1.mcu_last, b1.mcu_pixval,
                    b1.read_block_select, b1.read_buffer_select, b1.read_addr};

    always #5 clock = ~clock;

    // EBR models: data is addr^block, valid one cycle after rden
    always @(posedge clock) if (b1.rden) b1.read_data <= 8'(b1.read_addr ^ 9'(b1.read_block_select));
    always @(posedge clock) if (b2.rden) b2.read_data <= 8'(b2.read_addr ^ 9'(b2.read_block_select));

    function automatic logic [11:0] exp_rd(int i, int ne);
        int m = i / 64;
        return {3'(m % ne), 9'((m / ne) * 64 + i % 64)};
    endfunction

    function automatic logic [9:0] exp_pix(int i, int ne);
        int m = i / 64;
        int p = i % 64;
        int a = (m / ne) * 64 + p;
        return {p == 0, p == 63, 8'(a ^ (m % ne))};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        b1.mcu_ready = duty != 0 ? ($urandom_range(9) < 3) : 1'b1;
        #1;
        if (b1.rden) begin
            check("rd_in_band", 32'(ridx < exp_reads), 1);
            if (ridx < exp_reads)
                check("rd_addr", 32'({b1.read_block_select, b1.read_addr}), 32'(exp_rd(ridx, 5)));
            check("rd_bank", 32'(b1.read_buffer_select), bank_exp);
            if (!overrun) check("rd_not_front", 32'(b1.read_buffer_select != fb), 1);
            ridx++;
        end
        if (held) check("stall_hold", 32'({b1.mcu_valid, cur1}), 32'({1'b1, hold_val}));
        if (b1.mcu_valid && b1.mcu_ready) begin
            check("xfer_in_band", 32'(idx < exp_reads), 1);
            if (idx < exp_reads) check("xfer", 32'(cur1), 32'(exp_pix(idx, 5)));
            idx++;
        end
        held = b1.mcu_valid && !b1.mcu_ready;
        hold_val = cur1;
    endtask

    task automatic start_band(int d, int bank);
        duty = d;
        bank_exp = bank;
        exp_reads = 2560;
        idx = 0;
        ridx = 0;
        held = 1'b0;
        fb = ~fb;
        step();
        check("busy_on", 32'(busy), 1);
        step();
        check("lat_not_valid", 32'(b1.mcu_valid), 0);
        step();
        check("lat_valid", 32'(b1.mcu_valid), 1);
    endtask

    task automatic run_until(int n);
        for (int c = 0; c < 20000 && idx < n; c++) step();
        check("progress", 32'(idx), n);
    endtask

    task automatic finish_band();
        check("busy_at_last", 32'(busy), 1);
        for (int c = 0; c < 8 && busy; c++) step();
        check("busy_fall", 32'(busy), 0);
        check("xfer_cnt", 32'(idx), 2560);
        check("rd_cnt", 32'(ridx), 2560);
        check("fifo_empty", 32'(b1.mcu_valid), 0);
        repeat (20) step();
        check("no_extra_rd", 32'(ridx), 2560);
    endtask

    initial begin
        int i, r;
        b1.mcu_ready = 1'b1;
        b2.mcu_ready = 1'b1;
        duty = 0; held = 1'b0; idx = 0; ridx = 0; exp_reads = 0; bank_exp = 0;
        repeat (2) @(negedge clock);
        #1;
        check("reset_outs", 32'(outs1), 0);
        nreset = 1'b1;
        repeat (5) step();
        check("idle_no_rd", 32'(ridx), 0);

        start_band(0, 0);
        run_until(2560);
        finish_band();

        start_band(1, 1);
        run_until(2560);
        finish_band();

        start_band(1, 0);
        run_until(1000);
        fb = ~fb;
        step();
        check("overrun_set", 32'(overrun), 1);
        check("busy_keep", 32'(busy), 1);
        run_until(2560);
        finish_band();
        check("overrun_sticky", 32'(overrun), 1);

        start_band(0, 0);
        run_until(700);
        #2;
        nreset = 1'b0;
        fb = 1'b0;
        #1;
        check("async_reset", 32'(outs1), 0);
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        idx = 0; ridx = 0; exp_reads = 0; held = 1'b0;
        repeat (10) step();
        check("no_rd_after_rst", 32'(ridx), 0);
        check("overrun_clr", 32'(overrun), 0);
        start_band(0, 0);
        run_until(2560);
        finish_band();

        fb2 = 1'b1;
        i = 0;
        r = 0;
        for (int c = 0; c < 600 && (i < 128 || busy2); c++) begin
            @(negedge clock);
            #1;
            if (b2.rden) begin
                check("rd2_in_band", 32'(r < 128), 1);
                check("rd2_addr", 32'({b2.read_block_select, b2.read_addr}), 32'(exp_rd(r, 1)));
                r++;
            end
            if (b2.mcu_valid && b2.mcu_ready) begin
                check("xfer2", 32'({b2.mcu_first, b2.mcu_last, b2.mcu_pixval}), 32'(exp_pix(i, 1)));
                i++;
            end
        end
        check("xfer2_cnt", 32'(i), 128);
        check("rd2_cnt", 32'(r), 128);
        check("busy2_fall", 32'(busy2), 0);
        check("overrun2_clr", 32'(overrun2), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
